// File: rtl/sipo_deserializer.sv
// Serial-in / parallel-out deserializer with start-of-frame alignment and a
// pvalid/pack handshake. Define SIPO_PARITY_EN to add a trailing even-parity bit and perr.
module sipo_deserializer #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             start,
    input  logic             pack,
    output logic [WIDTH-1:0] pout,
    output logic             pvalid,
    output logic             busy,
    output logic             overrun
`ifdef SIPO_PARITY_EN
    ,
    output logic             perr
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] LAST_M1 = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1
`ifdef SIPO_PARITY_EN
        ,
        PAR  = 2'd2
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] word;
    logic             xfer;
    logic             parity_bad;

    // The first bit of a frame drifts to pout[WIDTH-1] or pout[0] as later bits arrive.
    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign shifted = {shreg_q[WIDTH-2:0], sin};
        end else begin : g_lsb
            assign shifted = {sin, shreg_q[WIDTH-1:1]};
        end
    endgenerate

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        word       = shreg_q;
        xfer       = 1'b0;
        parity_bad = 1'b0;
        case (state_q)
            IDLE: begin
                if (sin_en && start) begin
                    shreg_d = shifted;
                    cnt_d   = ONE;
                    state_d = RECV;
                end
            end
            RECV: begin
                if (sin_en) begin
                    shreg_d = shifted;
                    if (start) begin
                        cnt_d = ONE;
                    end else if (cnt_q == LAST_M1) begin
`ifdef SIPO_PARITY_EN
                        cnt_d   = cnt_q + ONE;
                        state_d = PAR;
`else
                        xfer    = 1'b1;
                        word    = shifted;
                        cnt_d   = '0;
                        state_d = IDLE;
`endif
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end
`ifdef SIPO_PARITY_EN
            PAR: begin
                if (sin_en) begin
                    if (start) begin
                        shreg_d = shifted;
                        cnt_d   = ONE;
                        state_d = RECV;
                    end else begin
                        xfer       = 1'b1;
                        parity_bad = ^{shreg_q, sin};
                        cnt_d      = '0;
                        state_d    = IDLE;
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            pout    <= '0;
            pvalid  <= 1'b0;
            overrun <= 1'b0;
`ifdef SIPO_PARITY_EN
            perr    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            if (xfer) begin
                pout   <= word;
                pvalid <= 1'b1;
                // A same-edge pack consumes the old word, so only an unacked overwrite counts.
                if (pvalid && !pack) overrun <= 1'b1;
`ifdef SIPO_PARITY_EN
                perr   <= parity_bad;
`endif
            end else if (pack) begin
                pvalid <= 1'b0;
            end
        end
    end

    assign busy = (state_q != IDLE);

`ifndef SIPO_PARITY_EN
    logic unused_parity;
    assign unused_parity = parity_bad;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench: two instances (MSB-first and LSB-first) share stimulus and
// are compared each cycle against a frame-queue reference model.
module tb_sipo_deserializer;

    localparam int W = 4;
`ifdef SIPO_PARITY_EN
    localparam int NBITS = W + 1;
`else
    localparam int NBITS = W;
`endif

    logic         clk = 1'b0;
    logic         rst, sin, sin_en, start, pack;
    logic [W-1:0] pout_m, pout_l;
    logic         pvalid_m, busy_m, overrun_m;
    logic         pvalid_l, busy_l, overrun_l;
`ifdef SIPO_PARITY_EN
    logic         perr_m, perr_l;
`endif

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en), .start(start), .pack(pack),
        .pout(pout_m), .pvalid(pvalid_m), .busy(busy_m), .overrun(overrun_m)
`ifdef SIPO_PARITY_EN
        , .perr(perr_m)
`endif
    );

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en), .start(start), .pack(pack),
        .pout(pout_l), .pvalid(pvalid_l), .busy(busy_l), .overrun(overrun_l)
`ifdef SIPO_PARITY_EN
        , .perr(perr_l)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: bits of the current frame, in arrival order.
    int           q[$];
    bit           m_busy, m_pvalid, m_ovr, m_perr;
    logic [W-1:0] m_pout_m, m_pout_l;
    int           rises;
    bit           prev_pvalid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit b, input bit en, input bit st, input bit pk);
        bit xfer;
        bit par;
        if (r) begin
            q.delete();
            m_busy = 0; m_pvalid = 0; m_ovr = 0; m_perr = 0;
            m_pout_m = '0; m_pout_l = '0;
            return;
        end
        xfer = 0;
        if (en && (st || m_busy)) begin
            if (st) q.delete();
            q.push_back(int'(b));
            m_busy = 1;
            if (q.size() == NBITS) xfer = 1;
        end
        if (xfer) begin
            if (m_pvalid && !pk) m_ovr = 1;
            m_pout_m = '0; m_pout_l = '0; par = 0;
            for (int i = 0; i < W; i++) begin
                m_pout_m = m_pout_m + W'(q[i] * (1 << (W - 1 - i)));
                m_pout_l = m_pout_l + W'(q[i] * (1 << i));
            end
            for (int i = 0; i < NBITS; i++) par = par ^ bit'(q[i]);
            m_perr   = par;
            m_pvalid = 1;
            q.delete();
            m_busy = 0;
        end else if (pk) begin
            m_pvalid = 0;
        end
    endtask

    task automatic compare_all();
        check("pout_msb", 32'(pout_m), 32'(m_pout_m));
        check("pout_lsb", 32'(pout_l), 32'(m_pout_l));
        check("pvalid", {30'd0, pvalid_l, pvalid_m}, {30'd0, m_pvalid, m_pvalid});
        check("busy", {30'd0, busy_l, busy_m}, {30'd0, m_busy, m_busy});
        check("overrun", {30'd0, overrun_l, overrun_m}, {30'd0, m_ovr, m_ovr});
`ifdef SIPO_PARITY_EN
        check("perr", {30'd0, perr_l, perr_m}, {30'd0, m_perr, m_perr});
`endif
    endtask

    // One clock: drive inputs, clock edge, update model, sample 1 time unit later.
    task automatic cycle(input bit r, input bit b, input bit en, input bit st, input bit pk);
        rst = r; sin = b; sin_en = en; start = st; pack = pk;
        @(posedge clk);
        model_step(r, b, en, st, pk);
        #1;
        if (pvalid_m && !prev_pvalid) rises++;
        prev_pvalid = pvalid_m;
        compare_all();
    endtask

    task automatic bit_in(input bit b, input bit st, input bit pk);
        cycle(0, b, 1, st, pk);
    endtask

    task automatic idle(input int n, input bit pk);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, pk);
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
    endtask

    task automatic parity_bit(input bit p, input bit pk);
`ifdef SIPO_PARITY_EN
        bit_in(p, 0, pk);
`endif
    endtask

    function automatic bit even_par(input logic [W-1:0] v);
        return ^v;
    endfunction

    initial begin
        rst = 1; sin = 0; sin_en = 0; start = 0; pack = 0;
        q.delete(); m_busy = 0; m_pvalid = 0; m_ovr = 0; m_perr = 0;
        m_pout_m = '0; m_pout_l = '0; rises = 0; prev_pvalid = 0;

        // Reset state
        do_reset();
        check("rst_pout", 32'(pout_m), 32'd0);
        check("rst_flags", {29'd0, pvalid_m, busy_m, overrun_m}, 32'd0);

        // Basic frame 1101, MSB-first and LSB-first, then ack
        bit_in(1, 1, 0); bit_in(1, 0, 0); bit_in(0, 0, 0); bit_in(1, 0, 0);
        parity_bit(even_par(4'b1101), 0);
        check("basic_msb", 32'(pout_m), 32'h0000000d);
        check("basic_lsb", 32'(pout_l), 32'h0000000b);
        check("basic_pvalid", 32'(pvalid_m), 32'd1);
        idle(1, 1);
        check("basic_ack", 32'(pvalid_m), 32'd0);
        idle(1, 1);
        check("ack_idle", 32'(pvalid_m), 32'd0);

        // Gaps of 3 idle cycles between bits 1,0,0,1; busy held through the gaps
        bit_in(1, 1, 0);
        for (int i = 1; i < 4; i++) begin
            idle(3, 0);
            check("gap_busy", 32'(busy_m), 32'd1);
            bit_in((i == 3), 0, 0);
        end
        parity_bit(even_par(4'b1001), 0);
        check("gap_pout", 32'(pout_m), 32'h9);
        idle(1, 1);

        // Restart after two bits: only 0110 delivered, single pvalid rise
        rises = 0;
        bit_in(1, 1, 0); bit_in(0, 0, 0);
        bit_in(0, 1, 0); bit_in(1, 0, 0); bit_in(1, 0, 0); bit_in(0, 0, 0);
        parity_bit(even_par(4'b0110), 0);
        idle(2, 0);
        check("restart_pout", 32'(pout_m), 32'h6);
        check("restart_rises", 32'(rises), 32'd1);
        idle(1, 1);

        // Overrun: 1101 then 0011 without ack
        do_reset();
        bit_in(1, 1, 0); bit_in(1, 0, 0); bit_in(0, 0, 0); bit_in(1, 0, 0);
        parity_bit(even_par(4'b1101), 0);
        bit_in(0, 1, 0); bit_in(0, 0, 0); bit_in(1, 0, 0); bit_in(1, 0, 0);
        parity_bit(even_par(4'b0011), 0);
        check("ovr_pout", 32'(pout_m), 32'h3);
        check("ovr_set", 32'(overrun_m), 32'd1);
        idle(3, 1);
        check("ovr_sticky", 32'(overrun_m), 32'd1);

        // Same frames, pack on the second transfer edge: no overrun
        do_reset();
        bit_in(1, 1, 0); bit_in(1, 0, 0); bit_in(0, 0, 0); bit_in(1, 0, 0);
        parity_bit(even_par(4'b1101), 0);
`ifdef SIPO_PARITY_EN
        bit_in(0, 1, 0); bit_in(0, 0, 0); bit_in(1, 0, 0); bit_in(1, 0, 0);
        bit_in(even_par(4'b0011), 0, 1);
`else
        bit_in(0, 1, 0); bit_in(0, 0, 0); bit_in(1, 0, 0); bit_in(1, 0, 1);
`endif
        check("ack_same_pout", 32'(pout_m), 32'h3);
        check("ack_same_pvalid", 32'(pvalid_m), 32'd1);
        check("ack_same_ovr", 32'(overrun_m), 32'd0);

`ifdef SIPO_PARITY_EN
        // Parity good / bad
        idle(1, 1);
        bit_in(1, 1, 0); bit_in(1, 0, 0); bit_in(0, 0, 0); bit_in(1, 0, 0); bit_in(1, 0, 1);
        check("par_good", 32'(perr_m), 32'd0);
        bit_in(1, 1, 0); bit_in(1, 0, 0); bit_in(0, 0, 0); bit_in(1, 0, 0); bit_in(0, 0, 1);
        check("par_bad", 32'(perr_m), 32'd1);
`endif

        // Reset mid-frame clears everything
        bit_in(1, 1, 0); bit_in(0, 0, 0);
        cycle(1, 1, 1, 1, 0);
        check("midrst_pout", 32'(pout_m), 32'd0);
        check("midrst_flags", {29'd0, pvalid_m, busy_m, overrun_m}, 32'd0);
        idle(1, 0);
        bit_in(1, 0, 0);
        check("midrst_ignored", 32'(busy_m), 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0), 1'($urandom),
                  ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 12),
                  ($urandom_range(0, 9) < 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sipo_deserializer.md
SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning word length in bits (legal 2..16).
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning first received bit lands in pout[WIDTH-1]; 0 means it lands in pout[0].
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port sin  input  1  serial data bit, the upstream PISO register's q.
REQ-006 SHALL have port sin_en  input  1  sin is a valid bit this cycle.
REQ-007 SHALL have port start  input  1  qualified by sin_en, marks the first bit of a frame.
REQ-008 SHALL have port pack  input  1  consumer acknowledge of pout.
REQ-009 SHALL have port pout  output  WIDTH  last completed word, registered.
REQ-010 SHALL have port pvalid  output  1  pout holds an unacknowledged word.
REQ-011 SHALL have port busy  output  1  frame in progress (state not IDLE).
REQ-012 SHALL have port overrun  output  1  sticky: a completed word overwrote an unacknowledged one.
REQ-013 SHALL have port perr  output  1  parity error of the word in pout; present only with SIPO_PARITY_EN.

Function
REQ-014 SHALL implement FSM states IDLE, RECV and, with SIPO_PARITY_EN, PAR.
REQ-015 SHALL, in IDLE: if sin_en=1 and start=1, capture sin as bit 1, set bit count to 1 and go to RECV; otherwise ignore sin.
REQ-016 SHALL, in RECV: capture sin on each sin_en=1 cycle and increment the count; cycles with sin_en=0 hold state.
REQ-017 SHALL, in RECV on sin_en=1 with start=1, abort the partial frame and restart it with that bit as bit 1; no word is delivered for the aborted frame.
REQ-018 SHALL, when the WIDTH-th bit is captured: transfer the word to pout and go to IDLE (no parity), or go to PAR (parity).
REQ-019 SHALL, in PAR on sin_en=1, take sin as the parity bit, transfer the word and go to IDLE; a start in PAR is treated as REQ-017.
REQ-020 SHALL update pout and assert pvalid on the clock edge that samples the last bit, so the word is visible the following cycle (latency 0 cycles after the final bit edge).
REQ-021 SHALL clear pvalid on any edge where pack=1 and no transfer occurs; pack while pvalid=0 is ignored.
REQ-022 SHALL, on a transfer with pvalid=1 and pack=0, overwrite pout, keep pvalid=1 and set overrun.
REQ-023 SHALL, on a transfer with pack=1 on the same edge, load the new word, keep pvalid=1 and leave overrun unchanged.
REQ-024 SHALL keep overrun set until rst.
REQ-025 SHALL drive busy=1 exactly when the state is RECV or PAR.

Reset
REQ-026 SHALL, with rst=1 at a clock edge, set state IDLE, bit count 0, pout all zeros, pvalid 0, overrun 0 and perr 0.
REQ-027 SHALL give rst priority over all other inputs, discarding any partial frame.

Configuration
REQ-028 SHALL provide macro SIPO_PARITY_EN.
REQ-029 SHALL, with SIPO_PARITY_EN defined, expect one even-parity bit after the data bits and, on transfer, set perr=1 if the XOR of the data bits and the parity bit is 1 (perr=0 otherwise); the word is delivered either way.
REQ-030 SHALL, without SIPO_PARITY_EN, omit the PAR state and the perr port, so a frame is exactly WIDTH bits.

Verification
REQ-031 SHALL cover: rst, then bits 1,1,0,1 with sin_en=1 and start on the first -> pout=4'b1101, pvalid=1 from the next cycle; pack -> pvalid=0.
REQ-032 SHALL cover: MSB_FIRST=0 with the same bits 1,1,0,1 -> pout=4'b1011.
REQ-033 SHALL cover: sin_en=0 gaps of 3 cycles between bits 1,0,0,1 -> pout=4'b1001 and busy=1 throughout the frame.
REQ-034 SHALL cover: start reasserted after 2 bits, then bits 0,1,1,0 -> pout=4'b0110 and exactly one pvalid rise.
REQ-035 SHALL cover: two frames 1101 then 0011 with no pack -> pout=4'b0011 and overrun=1; repeating with pack on the second transfer edge -> overrun=0.
REQ-036 SHALL cover: with SIPO_PARITY_EN, frame 1101 + parity 1 -> perr=0, frame 1101 + parity 0 -> perr=1; rst mid-frame -> all outputs zero, busy=0.
